m3d_block_scheduler: RTL and testbench
======================================

M3D_BLOCK_SCHEDULER -- requirements
Module: m3d_block_scheduler

Interface
REQ-001 SHALL have parameter MACRO_COLUMN, default 4, the number of query-buffer entries per query burst (QRY_BEATS = MACRO_COLUMN).
REQ-002 SHALL have parameter MACRO_ROW, default 32, which sets weight-burst length WR_BEATS = MACRO_ROW*MACRO_COLUMN (128).
REQ-003 SHALL have parameter OUT_PER_QRY, default 32, the number of cmOut handshakes one query burst produces.
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 1024, the watchdog limit in cycles.
REQ-005 Ports: clk  input  1  clock; all logic on the rising edge.
REQ-006 Ports: rst  input  1  asynchronous, active-high reset.
REQ-007 Ports: wr_req_vld  input  1 and wr_req_rdy  output  1, the weight-write requester handshake.
REQ-008 Ports: q_req_vld  input  1 and q_req_rdy  output  1, the query requester handshake.
REQ-009 Ports: blk_we  output  1 and blk_cme  output  1, the mode strobes to the compute block.
REQ-010 Ports: blk_data_in_vld  output  1 and blk_data_in_rdy  input  1, the block input handshake.
REQ-011 Ports: blk_sel_q  output  1, the upstream data mux select (1 = query source).
REQ-012 Ports: blk_cmOut_vld  input  1 and blk_cmOut_rdy  input  1, the monitored result handshake.
REQ-013 Ports: wr_done  output  1, q_done  output  1, err_timeout  output  1 (one-cycle pulses); state  output  2.

Function
REQ-014 SHALL implement FSM states IDLE=0, WR=1, QRY=2, DRAIN=3, driven on the state output.
REQ-015 In IDLE, a lone wr_req_vld SHALL move the FSM to WR and a lone q_req_vld SHALL move it to QRY on the next edge.
REQ-016 In IDLE with both requests valid, the FSM SHALL grant the class not granted last (last_grant register, reset = query, so write wins first).
REQ-017 blk_we SHALL be 1 only in WR; blk_cme SHALL be 1 in QRY and DRAIN; the two SHALL never be 1 together.
REQ-018 blk_sel_q SHALL be 1 in QRY and DRAIN and 0 otherwise.
REQ-019 blk_data_in_vld SHALL equal wr_req_vld in WR, q_req_vld in QRY, and 0 otherwise.
REQ-020 wr_req_rdy SHALL equal (WR & blk_data_in_rdy); q_req_rdy SHALL equal (QRY & blk_data_in_rdy); both SHALL be 0 elsewhere.
REQ-021 A beat counter SHALL increment on each accepted handshake in WR or QRY and SHALL clear on every state entry.
REQ-022 On the WR_BEATS-th write handshake, the FSM SHALL go to IDLE and pulse wr_done in the following cycle.
REQ-023 On the QRY_BEATS-th query handshake, the FSM SHALL go to DRAIN.
REQ-024 The output counter SHALL clear on QRY entry and count (blk_cmOut_vld & blk_cmOut_rdy) in QRY and DRAIN, including handshakes that coincide with the last query beat.
REQ-025 The output counter SHALL saturate at OUT_PER_QRY.
REQ-026 In DRAIN, once the output counter equals OUT_PER_QRY, the FSM SHALL go to IDLE and pulse q_done.
REQ-027 If QRY is left with OUT_PER_QRY outputs already counted, DRAIN SHALL last exactly one cycle.
REQ-028 cmOut handshakes in IDLE or WR SHALL be ignored.
REQ-029 The FSM SHALL spend at least one cycle in IDLE between bursts, so a grant occurs one cycle after IDLE entry.
REQ-030 Requests SHALL not preempt a burst in progress; a deasserted requester in WR or QRY SHALL leave the FSM stalled in that state.

Reset
REQ-031 rst SHALL asynchronously force state=IDLE, both counters=0, last_grant=query, and all outputs to 0.
REQ-032 A reset mid-burst SHALL abandon the burst with no done pulse; the first cycle after release SHALL be IDLE.

Configuration
REQ-033 With macro M3D_SCHED_WDOG_EN defined, a counter SHALL clear on DRAIN entry and on each cmOut handshake, and increment on every other DRAIN cycle.
REQ-034 With M3D_SCHED_WDOG_EN defined, when that counter reaches DRAIN_TIMEOUT the FSM SHALL go to IDLE and pulse err_timeout, with no q_done pulse.
REQ-035 Without M3D_SCHED_WDOG_EN, err_timeout SHALL be tied 0 and DRAIN SHALL wait indefinitely.

Verification
REQ-036 Write only: wr_req_vld=1 and blk_data_in_rdy=1 held -> blk_we=1 for exactly 128 handshakes, then wr_done pulse and state=0.
REQ-037 Query: 4 beats with 32 cmOut handshakes, 20 of them during QRY -> DRAIN, then q_done on the 32nd handshake, with blk_cme=1 throughout.
REQ-038 Both requests held continuously -> grants alternate WR, QRY, WR with a one-cycle IDLE between bursts, and blk_we/blk_cme never both 1.
REQ-039 blk_data_in_rdy toggled every other cycle during WR -> still exactly 128 beats counted and no early wr_done.
REQ-040 rst asserted at write beat 50 -> outputs are 0 immediately; after release, a query request is granted and no wr_done is seen.
REQ-041 With WDOG_EN and DRAIN_TIMEOUT=16, no cmOut during DRAIN -> err_timeout pulses 16 cycles after DRAIN entry, state=0, no q_done.

Source files
------------

// File: rtl/m3d_block_scheduler.sv
// m3d_block_scheduler: arbitrates weight-write and query bursts into a compute
// block. It drives the block's mode strobes and input handshake, and it
// watches the result stream to decide when a query has fully drained.
// Optional feature: define M3D_SCHED_WDOG_EN to add a drain watchdog that
// abandons a stuck DRAIN and pulses err_timeout.
module m3d_block_scheduler #(
  parameter int MACRO_COLUMN  = 4,
  parameter int MACRO_ROW     = 32,
  parameter int OUT_PER_QRY   = 32,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req_vld,
  output logic       wr_req_rdy,
  input  logic       q_req_vld,
  output logic       q_req_rdy,
  output logic       blk_we,
  output logic       blk_cme,
  output logic       blk_data_in_vld,
  input  logic       blk_data_in_rdy,
  output logic       blk_sel_q,
  input  logic       blk_cmOut_vld,
  input  logic       blk_cmOut_rdy,
  output logic       wr_done,
  output logic       q_done,
  output logic       err_timeout,
  output logic [1:0] state
);

  localparam int QRY_BEATS = MACRO_COLUMN;
  localparam int WR_BEATS  = MACRO_ROW * MACRO_COLUMN;
  localparam int MAX_BEATS = (WR_BEATS > QRY_BEATS) ? WR_BEATS : QRY_BEATS;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int OUT_W     = $clog2(OUT_PER_QRY + 1);

  localparam logic [BEAT_W-1:0] WR_LAST  = BEAT_W'(WR_BEATS - 1);
  localparam logic [BEAT_W-1:0] QRY_LAST = BEAT_W'(QRY_BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
  localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(OUT_PER_QRY);
  localparam logic [OUT_W-1:0]  OUT_ONE  = OUT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_QRY   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d, out_cnt_nx;
  logic               last_grant_q, last_grant_d;  // 1 = query granted last
  logic               wr_done_q, wr_done_d;
  logic               q_done_q, q_done_d;
  logic               wr_hs, q_hs, cm_hs;
  logic               drain_done, wd_fire, timeout_go;

  // Mode strobes and handshakes are pure decodes of the current state
  assign blk_we          = (state_q == S_WR);
  assign blk_cme         = (state_q == S_QRY) || (state_q == S_DRAIN);
  assign blk_sel_q       = blk_cme;
  assign blk_data_in_vld = ((state_q == S_WR) & wr_req_vld) | ((state_q == S_QRY) & q_req_vld);
  assign wr_req_rdy      = (state_q == S_WR) & blk_data_in_rdy;
  assign q_req_rdy       = (state_q == S_QRY) & blk_data_in_rdy;
  assign state           = state_q;
  assign wr_done         = wr_done_q;
  assign q_done          = q_done_q;

  assign wr_hs = wr_req_vld & wr_req_rdy;
  assign q_hs  = q_req_vld & q_req_rdy;
  assign cm_hs = blk_cmOut_vld & blk_cmOut_rdy;

  // Saturating result count including this cycle's handshake, so a drain
  // finishes on the very handshake that completes the query
  always_comb begin
    out_cnt_nx = out_cnt_q;
    if (blk_cme && cm_hs && (out_cnt_q != OUT_MAX)) out_cnt_nx = out_cnt_q + OUT_ONE;
  end

  assign drain_done = (out_cnt_nx == OUT_MAX);
  assign timeout_go = wd_fire & ~drain_done;

`ifdef M3D_SCHED_WDOG_EN
  localparam int WD_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DRAIN_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q;

  // Idle-drain counter fires when the upcoming increment would reach the limit
  assign wd_fire     = (state_q == S_DRAIN) && !cm_hs && (wd_cnt_q == WD_LAST);
  assign err_timeout = err_q;

  // Watchdog next value: restart on DRAIN entry and on every result handshake
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if ((state_d == S_DRAIN) && (state_q != S_DRAIN)) wd_cnt_d = '0;
    else if (state_q == S_DRAIN)                       wd_cnt_d = cm_hs ? '0 : wd_cnt_q + WD_ONE;
  end

  // Watchdog counter and timeout pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= timeout_go;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state, arbitration and done-pulse decode
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_done_d    = 1'b0;
    q_done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_req_vld && (!q_req_vld || last_grant_q)) begin
          state_d      = S_WR;
          last_grant_d = 1'b0;
        end else if (q_req_vld) begin
          state_d      = S_QRY;
          last_grant_d = 1'b1;
        end
      end
      S_WR: begin
        if (wr_hs && (beat_cnt_q == WR_LAST)) begin
          state_d   = S_IDLE;
          wr_done_d = 1'b1;
        end
      end
      S_QRY: begin
        if (q_hs && (beat_cnt_q == QRY_LAST)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d  = S_IDLE;
          q_done_d = 1'b1;
        end else if (timeout_go) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter next values: beats restart on any state change, outputs on QRY entry
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_d != state_q)  beat_cnt_d = '0;
    else if (wr_hs || q_hs)  beat_cnt_d = beat_cnt_q + BEAT_ONE;
    out_cnt_d = out_cnt_nx;
    if ((state_q == S_IDLE) && (state_d == S_QRY)) out_cnt_d = '0;
  end

  // State, counters, arbitration history and done pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      out_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      wr_done_q    <= 1'b0;
      q_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      out_cnt_q    <= out_cnt_d;
      last_grant_q <= last_grant_d;
      wr_done_q    <= wr_done_d;
      q_done_q     <= q_done_d;
    end
  end

endmodule

// File: tb/tb_m3d_block_scheduler.sv
// Self-checking bench for m3d_block_scheduler (default geometry: 128-beat
// writes, 4-beat queries, 32 results per query). Watchdog limit set to 16 so
// the M3D_SCHED_WDOG_EN build can exercise the timeout path.
module tb_m3d_block_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req_vld, wr_req_rdy, q_req_vld, q_req_rdy;
  logic       blk_we, blk_cme, blk_data_in_vld, blk_data_in_rdy, blk_sel_q;
  logic       blk_cmOut_vld, blk_cmOut_rdy;
  logic       wr_done, q_done, err_timeout;
  logic [1:0] state;
  logic [7:0] outs;

  m3d_block_scheduler #(
    .MACRO_COLUMN (4),
    .MACRO_ROW    (32),
    .OUT_PER_QRY  (32),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_req_vld     (wr_req_vld),
    .wr_req_rdy     (wr_req_rdy),
    .q_req_vld      (q_req_vld),
    .q_req_rdy      (q_req_rdy),
    .blk_we         (blk_we),
    .blk_cme        (blk_cme),
    .blk_data_in_vld(blk_data_in_vld),
    .blk_data_in_rdy(blk_data_in_rdy),
    .blk_sel_q      (blk_sel_q),
    .blk_cmOut_vld  (blk_cmOut_vld),
    .blk_cmOut_rdy  (blk_cmOut_rdy),
    .wr_done        (wr_done),
    .q_done         (q_done),
    .err_timeout    (err_timeout),
    .state          (state)
  );

  always #5 clk = ~clk;

  // {state, we, cme, sel_q, data_in_vld, wr_rdy, q_rdy}
  assign outs = {state, blk_we, blk_cme, blk_sel_q, blk_data_in_vld, wr_req_rdy, q_req_rdy};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic q, input logic rdy, input logic cm);
    wr_req_vld      = wr;
    q_req_vld       = q;
    blk_data_in_rdy = rdy;
    blk_cmOut_vld   = cm;
    blk_cmOut_rdy   = cm;
  endtask

  // Sticky monitors for properties that must hold across whole sequences
  logic both_seen = 1'b0, err_seen = 1'b0, wrd_watch = 1'b0, wrd_seen = 1'b0;
  always @(negedge clk) begin
    if (blk_we && blk_cme)     both_seen <= 1'b1;
    if (err_timeout)           err_seen  <= 1'b1;
    if (wrd_watch && wr_done)  wrd_seen  <= 1'b1;
  end

  typedef struct {
    logic       wr;
    logic       q;
    logic       rdy;
    logic       cm;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int   beats;
    int   cyc;
    logic early;
    logic bad;
    logic r;

    // idle, idle with stray cmOut, both requests (write wins first), then WR decodes
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'b00_000000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'b00_000000};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'b00_000000};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'b01_100100};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'b01_100010};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'b01_100110};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'b01_100110};

    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("reset_outs", int'(outs), 0);
    chk("reset_pulses", int'({wr_done, q_done, err_timeout}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].wr, tbl[i].q, tbl[i].rdy, tbl[i].cm);
      @(negedge clk);
      chk($sformatf("vec%0d", i), int'(outs), int'(tbl[i].exp));
      @(posedge clk); #1;
    end

    // Rest of the write burst with the block ready only every other cycle
    beats = 2;
    cyc   = 0;
    early = 1'b0;
    while (beats < 128 && cyc < 400) begin
      r = cyc[0];
      drive(1'b1, 1'b1, r, 1'b1);
      @(negedge clk);
      if (state != 2'd1 || wr_done) early = 1'b1;
      if (r) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("wr_no_early_done", int'(early), 0);
    chk("wr_beats_in_budget", beats, 128);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("wr_done_state", int'(state), 0);
    chk("wr_done_pulse", int'(wr_done), 1);
    chk("wr_done_we_low", int'(blk_we), 0);
    @(posedge clk); #1;

    // Query granted next (alternation); 20 results during QRY, beats in last 4 cycles
    bad = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      r = (c >= 17);
      drive(1'b1, 1'b1, r, 1'b1);
      @(negedge clk);
      if (outs !== {2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, r} || q_done) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("qry_phase", int'(bad), 0);
    bad = 1'b0;
    for (int d = 1; d <= 12; d++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      if (outs !== 8'b11_011000 || q_done) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("drain_phase", int'(bad), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("q_done_state", int'(state), 0);
    chk("q_done_pulse", int'(q_done), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("alt_grant_wr", int'(state), 1);
    @(posedge clk); #1;

    // Reset in the middle of a write burst at beat 50
    for (int b = 2; b <= 50; b++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    chk("pre_reset_state", int'(state), 1);
    #2;
    rst       = 1'b1;
    wrd_watch = 1'b1;
    #1;
    chk("rst_async_outs", int'(outs), 0);
    chk("rst_async_pulses", int'({wr_done, q_done, err_timeout}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_idle", int'(state), 0);
    @(posedge clk); #1;

    // Query whose results complete (and saturate) before QRY ends: one-cycle DRAIN
    bad = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      r = (c >= 32);
      drive(1'b0, 1'b1, r, 1'b1);
      @(negedge clk);
      if (outs !== {2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, r}) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("qry2_phase", int'(bad), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain1_state", int'(state), 3);
    chk("drain1_no_done", int'(q_done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain1_exit_state", int'(state), 0);
    chk("drain1_q_done", int'(q_done), 1);
    chk("no_wr_done_after_rst", int'(wrd_seen), 0);
    wrd_watch = 1'b0;

    // Query with no results at all: watchdog or indefinite wait
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("qry3_grant", int'(state), 2);
    for (int k = 0; k < 4; k++) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef M3D_SCHED_WDOG_EN
    bad = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (state != 2'd3 || err_timeout) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("wdog_wait", int'(bad), 0);
    @(negedge clk);
    chk("wdog_state", int'(state), 0);
    chk("wdog_err", int'(err_timeout), 1);
    chk("wdog_no_qdone", int'(q_done), 0);
`else
    bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (state != 2'd3 || err_timeout) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("drain_wait", int'(bad), 0);
    bad = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (state != 2'd3 || q_done) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("drain_late_results", int'(bad), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("late_q_done_state", int'(state), 0);
    chk("late_q_done_pulse", int'(q_done), 1);
    chk("no_err_timeout", int'(err_seen), 0);
`endif
    chk("we_cme_exclusive", int'(both_seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
